// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
//   N-channel tick / clock-enable generator running from the single board
//   clock. Each channel has its own runtime-loadable divisor D, run enable and
//   continuous/one-shot mode. A channel issues a 1-cycle tick strobe every
//   D+1 counting edges and toggles a square wave on every tick. A one-shot
//   channel fires once and then stays disarmed until it is rewritten.
//
// Ports
//   clk_100MHz   in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high
//   en           in   NUM_CH  per-channel run enable
//   cfg_we       in   1       config write strobe (single cycle)
//   cfg_ch       in   CH_W    channel addressed by cfg_we
//   cfg_div      in   CNT_W   divisor D to load
//   cfg_oneshot  in   1       mode to load: 0 continuous, 1 one-shot
//   tick         out  NUM_CH  registered 1-cycle strobe per channel
//   sq           out  NUM_CH  registered square wave, toggles on each tick
//   active       out  NUM_CH  channel armed (continuous, or one-shot unfired)
//
// Config handshake: there is no ready/back-pressure. A write is accepted on
// every rising edge where cfg_we is high; cfg_ch/cfg_div/cfg_oneshot are only
// meaningful in that cycle. Writes to cfg_ch >= NUM_CH are dropped.
// -----------------------------------------------------------------------------
module multi_tick_gen #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = CLK_HZ / 2 - 1,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] active
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  // Per-channel state
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  r_div [NUM_CH];
  logic [NUM_CH-1:0] r_oneshot;
  logic [NUM_CH-1:0] r_active;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_sq;

  // Per-channel decode
  logic [NUM_CH-1:0] w_sel;   // this channel is the target of a config write
  logic [NUM_CH-1:0] w_run;   // counting this edge
  logic [NUM_CH-1:0] w_wrap;  // counting and terminal count reached

  always_comb begin
    w_sel  = '0;
    w_run  = '0;
    w_wrap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel numbers never match any i, so they are ignored.
      w_sel[i]  = cfg_we && (cfg_ch == CH_W'(i));
      w_run[i]  = en[i] && r_active[i];
      // Compare before increment: cnt stops at div, so D = all-ones never
      // overflows the counter.
      w_wrap[i] = w_run[i] && (r_cnt[i] == r_div[i]);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        r_cnt[i]     <= '0;
        r_div[i]     <= RST_DIV;
        r_oneshot[i] <= 1'b0;
        r_active[i]  <= 1'b1;
        r_tick[i]    <= 1'b0;
        r_sq[i]      <= 1'b0;
      end else if (w_sel[i]) begin
        // A load wins over a same-cycle wrap: the pending tick is discarded
        // and counting restarts from zero with the new divisor. sq keeps its
        // phase.
        r_div[i]     <= cfg_div;
        r_oneshot[i] <= cfg_oneshot;
        r_cnt[i]     <= '0;
        r_active[i]  <= 1'b1;
        r_tick[i]    <= 1'b0;
      end else if (w_wrap[i]) begin
        r_cnt[i]  <= '0;
        r_tick[i] <= 1'b1;
        r_sq[i]   <= ~r_sq[i];
        if (r_oneshot[i]) begin
          r_active[i] <= 1'b0;
        end
      end else if (w_run[i]) begin
        r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
        r_tick[i] <= 1'b0;
      end else begin
        // Disabled or spent one-shot: count and square wave freeze.
        r_tick[i] <= 1'b0;
      end
    end
  end

  assign tick   = r_tick;
  assign sq     = r_sq;
  assign active = r_active;

endmodule

// File: tb/tb_multi_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_tick_gen
//   Directed scenarios followed by randomized traffic for multi_tick_gen.
//   The reference model describes each channel as "edges remaining until the
//   next tick": a load or reset sets it to D+1, every enabled armed edge
//   takes one away, and reaching zero produces a tick, flips the square wave
//   and starts a new period (or disarms a one-shot channel).
// -----------------------------------------------------------------------------
module tb_multi_tick_gen;

  localparam int CLK_HZ = 10;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 4;
  localparam int DEF_DIV = CLK_HZ / 2 - 1;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int W      = 3 * NUM_CH;

  // ---------------------------------------------------------------- clock/reset
  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic              reset       = 1'b1;
  logic [NUM_CH-1:0] en          = '0;
  logic              cfg_we      = 1'b0;
  logic [CH_W-1:0]   cfg_ch      = '0;
  logic [CNT_W-1:0]  cfg_div     = '0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] active;

  multi_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .tick        (tick),
    .sq          (sq),
    .active      (active)
  );

  // ---------------------------------------------------------------- reference model
  longint            m_rem [NUM_CH];
  longint            m_div [NUM_CH];
  bit                m_os  [NUM_CH];
  logic [NUM_CH-1:0] m_tick = '0;
  logic [NUM_CH-1:0] m_sq   = '0;
  logic [NUM_CH-1:0] m_act  = '1;

  logic [W-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs presented to it.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_div[c]  = DEF_DIV;
        m_rem[c]  = DEF_DIV + 1;
        m_os[c]   = 1'b0;
        m_act[c]  = 1'b1;
        m_tick[c] = 1'b0;
        m_sq[c]   = 1'b0;
      end else if (cfg_we && int'(cfg_ch) == c) begin
        m_div[c]  = longint'(cfg_div);
        m_rem[c]  = longint'(cfg_div) + 1;
        m_os[c]   = cfg_oneshot;
        m_act[c]  = 1'b1;
        m_tick[c] = 1'b0;
      end else if (en[c] && m_act[c]) begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          m_tick[c] = 1'b1;
          m_sq[c]   = ~m_sq[c];
          m_rem[c]  = m_div[c] + 1;
          if (m_os[c]) m_act[c] = 1'b0;
        end else begin
          m_tick[c] = 1'b0;
        end
      end else begin
        m_tick[c] = 1'b0;
      end
    end
    exp_q.push_back({m_act, m_sq, m_tick});
  endtask

  task automatic scoreboard_check();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("tick",   32'(tick),   32'(e[NUM_CH-1:0]));
    check("sq",     32'(sq),     32'(e[2*NUM_CH-1:NUM_CH]));
    check("active", 32'(active), 32'(e[3*NUM_CH-1:2*NUM_CH]));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic cyc(input logic rst, input logic [NUM_CH-1:0] e, input logic we,
                     input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d, input logic os);
    reset       = rst;
    en          = e;
    cfg_we      = we;
    cfg_ch      = ch;
    cfg_div     = d;
    cfg_oneshot = os;
    @(posedge clk_100MHz);
    model_edge();
    #1;
    scoreboard_check();
  endtask

  task automatic run(input int n, input logic [NUM_CH-1:0] e);
    for (int k = 0; k < n; k++) cyc(1'b0, e, 1'b0, '0, '0, 1'b0);
  endtask

  localparam logic [NUM_CH-1:0] ALL = '1;

  // ---------------------------------------------------------------- stimulus
  initial begin
    int guard;
    logic [NUM_CH-1:0] e_r;

    // T1: reset, then all channels free-running at the default divisor
    cyc(1'b1, '0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, '0, 1'b0, '0, '0, 1'b0);
    check("rst_tick",   32'(tick),   32'd0);
    check("rst_sq",     32'(sq),     32'd0);
    check("rst_active", 32'(active), 32'(ALL));
    run(4, ALL);
    check("t1_no_tick_yet", 32'(tick), 32'd0);
    run(1, ALL);
    check("t1_first_tick_all", 32'(tick), 32'(ALL));
    run(15, ALL);

    // T2: ch1 D=0 continuous -> tick every cycle
    cyc(1'b0, ALL, 1'b1, CH_W'(1), 4'd0, 1'b0);
    run(1, ALL);
    check("t2_tick1_first", 32'(tick[1]), 32'd1);
    run(6, ALL);

    // T3: load ch2 on the very edge where it would have wrapped
    guard = 0;
    while (m_rem[2] != 1 && guard < 40) begin
      run(1, ALL);
      guard++;
    end
    check("t3_align_timeout", 32'(guard < 40), 32'd1);
    cyc(1'b0, ALL, 1'b1, CH_W'(2), 4'd3, 1'b0);
    check("t3_no_tick", 32'(tick[2]), 32'd0);
    run(3, ALL);
    check("t3_wait", 32'(tick[2]), 32'd0);
    run(1, ALL);
    check("t3_tick_after_4", 32'(tick[2]), 32'd1);
    run(4, ALL);

    // T4: ch0 D=9, pause at cnt=5 for 7 cycles, then resume
    cyc(1'b0, ALL, 1'b1, CH_W'(0), 4'd9, 1'b0);
    run(5, ALL);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, ALL & ~NUM_CH'(1), 1'b0, '0, '0, 1'b0);
      check("t4_off_tick", 32'(tick[0]), 32'd0);
    end
    run(12, ALL);

    // T5: ch3 one-shot D=2, then rewrite to re-arm
    cyc(1'b0, ALL, 1'b1, CH_W'(3), 4'd2, 1'b1);
    run(3, ALL);
    check("t5_fire", 32'(tick[3]), 32'd1);
    check("t5_spent", 32'(active[3]), 32'd0);
    run(8, ALL);
    run(3, ALL & ~NUM_CH'(8));
    run(3, ALL);
    check("t5_still_spent", 32'(active[3]), 32'd0);
    cyc(1'b0, ALL, 1'b1, CH_W'(3), 4'd2, 1'b1);
    check("t5_rearm", 32'(active[3]), 32'd1);
    run(6, ALL);

    // T6: reset mid-count, then an out-of-range write
    run(2, ALL);
    cyc(1'b1, ALL, 1'b0, '0, '0, 1'b0);
    check("t6_rst_tick",   32'(tick),   32'd0);
    check("t6_rst_sq",     32'(sq),     32'd0);
    check("t6_rst_active", 32'(active), 32'(ALL));
    cyc(1'b0, ALL, 1'b1, CH_W'(NUM_CH), 4'd0, 1'b1);
    run(12, ALL);

    // Largest divisor on ch4
    cyc(1'b0, ALL, 1'b1, CH_W'(4), 4'hF, 1'b0);
    run(34, ALL);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) e_r[c] = ($urandom_range(0, 99) < 85);
      cyc($urandom_range(0, 299) == 0,
          e_r,
          $urandom_range(0, 7) == 0,
          CH_W'($urandom_range(0, (1 << CH_W) - 1)),
          ($urandom_range(0, 4) == 0) ? 4'hF : CNT_W'($urandom_range(0, 6)),
          $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
